// File: rtl/dmem_pkg.sv
// Shared encodings for the LSU data-memory responder:
// access sizes, FSM states and wait-counter width.
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-wide storage with per-byte write enables,
// synchronous write and combinational read.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder with fixed latency.
// Define DMEM_RESP_ERR_CHECK_EN to fault illegal/misaligned/out-of-range.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             we_q, uns_q, err_p;
  size_e            size_q, sz;
  logic [AW+1:0]    addr_q;
  logic [31:0]      wdata_q, rdata_q;
  logic             err_q, acc_err, go;
  logic [3:0]       be;
  logic [31:0]      wlane, ld, ram_rdata;
  logic [31:0]      sh_b, sh_h;

`ifdef DMEM_RESP_ERR_CHECK_EN
  assign acc_err = (req_size == SZ_ILL)
                 | (req_size == SZ_HALF && req_addr[0])
                 | (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                 | (req_addr[31:2] >= 30'(DEPTH_WORDS));
`else
  logic unused_addr;
  assign acc_err = 1'b0;
  assign unused_addr = ^req_addr[31:AW+2];
`endif

  assign go = (state == WAIT) && (cnt == '0);

  // Illegal size behaves as word when faults are not flagged
  assign sz = (size_q == SZ_ILL) ? SZ_WORD : size_q;
  assign sh_b = ram_rdata >> {addr_q[1:0], 3'b000};
  assign sh_h = ram_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    ld    = ram_rdata;
    unique case (1'b1)
      sz == SZ_BYTE: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
        ld    = {{24{~uns_q & sh_b[7]}}, sh_b[7:0]};
      end
      sz == SZ_HALF: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
        ld    = {{16{~uns_q & sh_h[15]}}, sh_h[15:0]};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
        ld    = ram_rdata;
      end
    endcase
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (go & we_q & ~err_p),
    .be    (be),
    .addr  (addr_q[AW+1:2]),
    .wdata (wlane),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        cnt     <= CNT_W'(WAIT_CYCLES);
        we_q    <= req_we;
        size_q  <= size_e'(req_size);
        uns_q   <= req_unsigned;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        err_p   <= acc_err;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (go) begin
        rdata_q <= (we_q | err_p) ? 32'h0 : ld;
        err_q   <= err_p;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench: a WAIT_CYCLES=1 instance for data paths
// and a WAIT_CYCLES=3 instance for latency and reset abort.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_ready, rsp_err;

  logic        s_rst, s_req_valid, s_req_ready, s_req_we, s_req_unsigned;
  logic [1:0]  s_req_size;
  logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_slow (
    .clk(clk), .rst(s_rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_we(s_req_we), .req_size(s_req_size),
    .req_unsigned(s_req_unsigned), .req_addr(s_req_addr),
    .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err)
  );

  task automatic xact(input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL xact_timeout addr=%h valid=%b required=1", a, rsp_valid);
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xact_s(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    s_req_valid = 1'b1; s_req_we = we; s_req_size = 2'b10;
    s_req_unsigned = 1'b0; s_req_addr = a; s_req_wdata = wd;
    s_rsp_ready = 1'b0;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    lat = 0;
    while (s_rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (s_rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL xact_s_timeout addr=%h valid=%b required=1", a, s_rsp_valid);
    end
    rd = s_rsp_rdata;
    er = s_rsp_err;
    s_rsp_ready = 1'b1;
    @(posedge clk); #1;
    s_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; s_rst = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_fast ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    tests++;
    if (s_req_ready !== 1'b1 || s_rsp_valid !== 1'b0 ||
        s_rsp_rdata !== 32'h0 || s_rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_slow ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
               s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd;
    logic er;
    int lat;
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    tests++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
      fails++;
      $display("FAIL store_word lat=%0d rdata=%h err=%b required 2 0 0", lat, rd, er);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    tests++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      fails++;
      $display("FAIL load_word lat=%0d rdata=%h err=%b required 2 deadbeef 0", lat, rd, er);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd;
    logic er;
    int lat;
    logic        v_we  [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
    logic [1:0]  v_sz  [8] = '{0, 0, 1, 2, 1, 0, 0, 1};
    logic        v_un  [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
    logic [31:0] v_a   [8] = '{32'h13, 32'h13, 32'h12, 32'h10,
                               32'h12, 32'h11, 32'h11, 32'h10};
    logic [31:0] v_wd  [8] = '{0, 0, 32'hFFFF1234, 0, 0, 32'hFFFFFF80, 0, 0};
    logic [31:0] v_exp [8] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0, 32'h1234BEEF,
                               32'h00001234, 32'h0, 32'h00000080, 32'hFFFF80EF};
    for (int i = 0; i < 8; i++) begin
      xact(v_we[i], v_sz[i], v_un[i], v_a[i], v_wd[i], rd, er, lat);
      tests++;
      if (rd !== v_exp[i] || er !== 1'b0 || lat !== 2) begin
        fails++;
        $display("FAIL subword[%0d] rdata=%h err=%b lat=%0d required %h 0 2",
                 i, rd, er, lat, v_exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h123480EF || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d] valid=%b rdata=%h ready=%b required 1 123480ef 0",
                 c, rsp_valid, rsp_rdata, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_release ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_cfg();
    logic [31:0] rd;
    logic er;
    int lat;
`ifdef DMEM_RESP_ERR_CHECK_EN
    logic        v_we  [5] = '{1, 0, 0, 0, 0};
    logic [1:0]  v_sz  [5] = '{2, 2, 2, 1, 3};
    logic        v_un  [5] = '{0, 0, 0, 1, 0};
    logic [31:0] v_a   [5] = '{32'h11, 32'h10, 32'h1000, 32'h11, 32'h10};
    logic [31:0] v_exp [5] = '{32'h0, 32'h123480EF, 32'h0, 32'h0, 32'h0};
    logic        v_err [5] = '{1, 0, 1, 1, 1};
`else
    logic        v_we  [5] = '{1, 0, 0, 0, 0};
    logic [1:0]  v_sz  [5] = '{2, 2, 3, 1, 0};
    logic        v_un  [5] = '{0, 0, 0, 1, 0};
    logic [31:0] v_a   [5] = '{32'h11, 32'h1010, 32'h10, 32'h11, 32'h12};
    logic [31:0] v_exp [5] = '{32'h0, 32'hCAFEF00D, 32'hCAFEF00D,
                               32'h0000F00D, 32'hFFFFFFFE};
    logic        v_err [5] = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      xact(v_we[i], v_sz[i], v_un[i], v_a[i], 32'hCAFEF00D, rd, er, lat);
      tests++;
      if (rd !== v_exp[i] || er !== v_err[i] || lat !== 2) begin
        fails++;
        $display("FAIL cfg[%0d] rdata=%h err=%b lat=%0d required %h %b 2",
                 i, rd, er, lat, v_exp[i], v_err[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic er;
    int lat;
    xact_s(1'b1, 32'h20, 32'h55AA55AA, rd, er, lat);
    tests++;
    if (lat !== 4 || er !== 1'b0) begin
      fails++;
      $display("FAIL slow_store lat=%0d err=%b required 4 0", lat, er);
    end
    s_req_valid = 1'b1; s_req_we = 1'b1; s_req_addr = 32'h20;
    s_req_wdata = 32'h12345678; s_req_size = 2'b10;
    @(posedge clk); #1;
    s_req_valid = 1'b0;
    @(posedge clk); #1;
    s_rst = 1'b1;
    @(posedge clk); #1;
    s_rst = 1'b0;
    tests++;
    if (s_rsp_valid !== 1'b0 || s_rsp_rdata !== 32'h0 ||
        s_rsp_err !== 1'b0 || s_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_outputs valid=%b rdata=%h err=%b ready=%b required 0 0 0 1",
               s_rsp_valid, s_rsp_rdata, s_rsp_err, s_req_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    xact_s(1'b0, 32'h20, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h55AA55AA || er !== 1'b0 || lat !== 4) begin
      fails++;
      $display("FAIL abort_load rdata=%h err=%b lat=%0d required 55aa55aa 0 4", rd, er, lat);
    end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
        rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL resp_reset valid=%b rdata=%h err=%b ready=%b required 0 0 0 1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    s_req_valid = 1'b0; s_req_we = 1'b0; s_req_size = 2'b00;
    s_req_unsigned = 1'b0; s_req_addr = '0; s_req_wdata = '0;
    s_rsp_ready = 1'b0;
    test_reset();
    test_word();
    test_subword();
    test_hold();
    test_cfg();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words held; legal values are powers of two from 16 to 65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra access-latency cycles; legal range is 0 to 15.
REQ-003 SHALL provide port clk, input, 1, meaning the single clock, rising-edge.
REQ-004 SHALL provide port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-005 SHALL provide port req_valid, input, 1, meaning the LSU presents a request.
REQ-006 SHALL provide port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 SHALL provide port req_we, input, 1, meaning 1=store, 0=load.
REQ-008 SHALL provide port req_size, input, 2, meaning 00=byte, 01=half, 10=word, 11=illegal.
REQ-009 SHALL provide port req_unsigned, input, 1, meaning zero-extend load data instead of sign-extend.
REQ-010 SHALL provide port req_addr, input, 32, meaning byte address.
REQ-011 SHALL provide port req_wdata, input, 32, meaning store data, right-aligned.
REQ-012 SHALL provide port rsp_valid, output, 1, meaning a response is presented.
REQ-013 SHALL provide port rsp_ready, input, 1, meaning the LSU consumes the response.
REQ-014 SHALL provide port rsp_rdata, output, 32, meaning extended load data; 0 for stores and errors.
REQ-015 SHALL provide port rsp_err, output, 1, meaning the access faulted and had no effect.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE, so at most one request is outstanding.
REQ-017 SHALL accept on the edge where req_valid&&req_ready, capture all req_* fields, load wait counter with WAIT_CYCLES, and enter WAIT.
REQ-018 In WAIT with counter>0, SHALL decrement; with counter==0, SHALL perform the access and enter RESP on that edge.
REQ-019 Latency SHALL be WAIT_CYCLES+1 cycles from the acceptance edge to rsp_valid=1 (WAIT_CYCLES=0 gives rsp_valid in the cycle after acceptance).
REQ-020 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_valid&&rsp_ready, then return to IDLE on that edge; a new request is not accepted in that same cycle.
REQ-021 Word index SHALL be req_addr[31:2] modulo DEPTH_WORDS unless REQ-027 applies.
REQ-022 Byte load SHALL select lane addr[1:0]; half load SHALL select half addr[1]; result extended per req_unsigned; word load returns the whole word.
REQ-023 Byte store SHALL write only lane addr[1:0] from wdata[7:0]; half store SHALL write half addr[1] from wdata[15:0]; word store SHALL write all four bytes; other bytes are unchanged.
REQ-024 The store SHALL commit on exactly the WAIT-exit edge and never otherwise.

Reset
REQ-025 When rst=1 at an edge, SHALL enter IDLE, clear counter, and drive rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 in the following cycle.
REQ-026 Reset during WAIT or RESP SHALL abort the transaction with no store committed; memory contents are not cleared by reset.

Configuration
REQ-027 With macro DMEM_RESP_ERR_CHECK_EN defined, SHALL flag rsp_err=1 and suppress any store for: req_size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2]>=DEPTH_WORDS; latency is unchanged.
REQ-028 Without DMEM_RESP_ERR_CHECK_EN, rsp_err SHALL be constant 0, req_size=11 SHALL be treated as word, misaligned offsets SHALL be forced down to natural alignment, and addresses SHALL wrap modulo DEPTH_WORDS.

Structure
REQ-029 Size encodings, the FSM state encoding and the counter width SHALL reside in shared package dmem_pkg.
REQ-030 The storage array with a 4-bit byte-write-enable and a synchronous write SHALL be a sub-module named dmem_ram.

Verification
REQ-031 Store word 0xDEADBEEF at 0x10, then load word at 0x10 with WAIT_CYCLES=1 -> rsp_valid 2 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-032 Load byte at 0x13, signed then unsigned -> 0xFFFFFFDE, then 0x000000DE; store half 0x1234 at 0x12, then load word at 0x10 -> 0x1234BEEF.
REQ-033 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0 throughout; with rsp_ready=1 -> IDLE next cycle.
REQ-034 With ERR_CHECK_EN, store word at 0x11 -> err=1, rdata=0, word at 0x10 is unchanged; with DEPTH_WORDS=1024, load at 0x1000 -> err=1.
REQ-035 Assert rst in the WAIT cycle of a store with WAIT_CYCLES=3 -> outputs are 0, and a later load shows the old data.
